alu16_bist: RTL and testbench

ALU16_BIST -- requirements
Module: alu16_bist

---
 rtl/alu16_bist.sv | 183 ++++++++++++++++++
 tb/tb_alu16_bist.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_bist.sv
// rtl/alu16_bist.sv - built-in self test sequencer for a 16-bit five-opcode ALU
//
// Drives LFSR-derived operand pairs through every opcode (add, sub, and, or,
// xor), compares the ALU's combinational result against a locally computed
// value, and reports a mismatch count plus details of the first mismatch.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           run request, honoured only when idle or done
//   alu_a, alu_b    registered operands to the ALU under test
//   alu_ctrl        registered opcode to the ALU under test (000..100)
//   alu_result      combinational result from the ALU under test
//   busy            run in progress (APPLY, WAIT, CHECK)
//   done            run complete, held until next start or reset
//   pass            done with zero mismatches
//   fail_count      mismatch count, saturating at 255
//   first_fail_op   opcode of the first mismatch
//   first_fail_vec  per-opcode vector index of the first mismatch
//   first_fail_got  alu_result observed at the first mismatch
module alu16_bist #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          VEC_PER_OP    = 8,
    parameter int          SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [2:0]  first_fail_op,
    output logic [7:0]  first_fail_vec,
    output logic [15:0] first_fail_got
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int          SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  LAST_VEC    = 8'(VEC_PER_OP - 1);
    localparam logic [2:0]  LAST_OP     = 3'b100;

    state_t        state;
    logic [15:0]   lfsr;
    logic [7:0]    vec;
    logic [SW-1:0] settle_cnt;

    // Galois right-shift with taps 16'hB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        lfsr_step = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Operand b is the byte-swapped, inverted LFSR state so that a and b
    // are decorrelated enough to exercise carries and borrows.
    function automatic logic [15:0] make_b(input logic [15:0] l);
        make_b = ~{l[7:0], l[15:8]};
    endfunction

    logic [15:0] expected;
    logic        mismatch;
    logic [15:0] lfsr_nxt;
    logic        last_vec;

    always_comb begin
        expected = 16'h0000;
        case (alu_ctrl)
            3'b000:  expected = alu_a + alu_b;
            3'b001:  expected = alu_a - alu_b;
            3'b010:  expected = alu_a & alu_b;
            3'b011:  expected = alu_a | alu_b;
            3'b100:  expected = alu_a ^ alu_b;
            default: expected = 16'h0000;
        endcase
    end

    // Case inequality so an undriven or X result is never accepted as a match.
    assign mismatch = (alu_result !== expected);
    assign lfsr_nxt = lfsr_step(lfsr);
    assign last_vec = (vec == LAST_VEC);

    // alu_ctrl doubles as the opcode loop register: it is only ever loaded
    // with the current opcode during a run, and held as-is in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            lfsr           <= SEED;
            vec            <= 8'd0;
            settle_cnt     <= '0;
            alu_a          <= 16'h0000;
            alu_b          <= 16'h0000;
            alu_ctrl       <= 3'b000;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 8'd0;
            first_fail_op  <= 3'b000;
            first_fail_vec <= 8'd0;
            first_fail_got <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_APPLY;
                        lfsr           <= SEED;
                        vec            <= 8'd0;
                        alu_a          <= SEED;
                        alu_b          <= make_b(SEED);
                        alu_ctrl       <= 3'b000;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= 8'd0;
                        first_fail_op  <= 3'b000;
                        first_fail_vec <= 8'd0;
                        first_fail_got <= 16'h0000;
                    end
                end

                ST_APPLY: begin
                    state      <= ST_WAIT;
                    settle_cnt <= '0;
                end

                ST_WAIT: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        if (fail_count != 8'hFF) begin
                            fail_count <= fail_count + 8'd1;
                        end
                        // fail_count saturates and never returns to zero,
                        // so zero means no mismatch seen yet this run.
                        if (fail_count == 8'd0) begin
                            first_fail_op  <= alu_ctrl;
                            first_fail_vec <= vec;
                            first_fail_got <= alu_result;
                        end
                    end
                    lfsr <= lfsr_nxt;
                    if (last_vec && (alu_ctrl == LAST_OP)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == 8'd0) && !mismatch;
                    end else begin
                        state <= ST_APPLY;
                        alu_a <= lfsr_nxt;
                        alu_b <= make_b(lfsr_nxt);
                        if (last_vec) begin
                            vec      <= 8'd0;
                            alu_ctrl <= alu_ctrl + 3'd1;
                        end else begin
                            vec <= vec + 8'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_bist.sv
// tb/tb_alu16_bist.sv - self-checking bench for alu16_bist
module tb_alu16_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start, start64, start3;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                            input logic [2:0] op);
        case (op)
            3'b000:  alu_ref = x + y;
            3'b001:  alu_ref = x - y;
            3'b010:  alu_ref = x & y;
            3'b011:  alu_ref = x | y;
            3'b100:  alu_ref = x ^ y;
            default: alu_ref = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_model(input logic [15:0] l);
        lfsr_model = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // default-parameter instance
    logic [15:0] a, b, res, ffg;
    logic [2:0]  ctrl, ffo;
    logic        busy, done, pass;
    logic [7:0]  fc, ffv;
    int          mode = 0;

    always_comb begin
        res = alu_ref(a, b, ctrl);
        if (mode == 1 && ctrl == 3'b010) res = 16'hFFFF;
        if (mode == 2) res = ~alu_ref(a, b, ctrl);
    end

    alu16_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alu_a(a), .alu_b(b), .alu_ctrl(ctrl), .alu_result(res),
        .busy(busy), .done(done), .pass(pass), .fail_count(fc),
        .first_fail_op(ffo), .first_fail_vec(ffv), .first_fail_got(ffg)
    );

    // VEC_PER_OP=64 instance with an always-wrong ALU
    logic [15:0] a64, b64, res64, ffg64;
    logic [2:0]  ctrl64, ffo64;
    logic        busy64, done64, pass64;
    logic [7:0]  fc64, ffv64;

    assign res64 = ~alu_ref(a64, b64, ctrl64);

    alu16_bist #(.VEC_PER_OP(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64),
        .alu_a(a64), .alu_b(b64), .alu_ctrl(ctrl64), .alu_result(res64),
        .busy(busy64), .done(done64), .pass(pass64), .fail_count(fc64),
        .first_fail_op(ffo64), .first_fail_vec(ffv64), .first_fail_got(ffg64)
    );

    // SETTLE_CYCLES=3 instance with a two-cycle-latency ALU
    logic [15:0] a3, b3, ffg3, d1, d2;
    logic [2:0]  ctrl3, ffo3;
    logic        busy3, done3, pass3;
    logic [7:0]  fc3, ffv3;

    always @(posedge clk) begin
        d1 <= alu_ref(a3, b3, ctrl3);
        d2 <= d1;
    end

    alu16_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .alu_a(a3), .alu_b(b3), .alu_ctrl(ctrl3), .alu_result(d2),
        .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3),
        .first_fail_op(ffo3), .first_fail_vec(ffv3), .first_fail_got(ffg3)
    );

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [2:0]  op;
    } vec_t;

    vec_t exp_q[$];

    task automatic push_vectors(input int n);
        logic [15:0] l = 16'hACE1;
        vec_t e;
        for (int op = 0; op < 5; op++) begin
            for (int v = 0; v < n; v++) begin
                e.va = l;
                e.vb = ~{l[7:0], l[15:8]};
                e.op = 3'(op);
                exp_q.push_back(e);
                l = lfsr_model(l);
            end
        end
    endtask

    // Leaves the caller 1 time unit after the start-sampling edge.
    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        if (which == 0) start = 1'b1; else if (which == 1) start64 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start64 = 1'b0; start3 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
        end
        n_cmp++; if ({a, b, ctrl} !== 35'd0) begin
            n_bad++; $display("FAIL reset_operands: got a=%h b=%h ctrl=%b want 0", a, b, ctrl);
        end
        n_cmp++; if ({fc, ffo, ffv, ffg} !== 35'd0) begin
            n_bad++; $display("FAIL reset_counters: got fc=%0d op=%b vec=%0d got=%h want 0", fc, ffo, ffv, ffg);
        end
        n_cmp++; if (busy64 !== 1'b0 || done3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_other: got busy64=%b done3=%b want 0 0", busy64, done3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pass_run(input string tag);
        vec_t e;
        logic [15:0] prev_a = 16'h0000;
        int pops = 0;
        mode = 0;
        exp_q.delete();
        push_vectors(8);
        pulse_start(0);
        n_cmp++; if (a !== 16'hACE1 || b !== 16'h1E53 || ctrl !== 3'b000) begin
            n_bad++; $display("FAIL %s_first_vec: got %h %h %b want ace1 1e53 000", tag, a, b, ctrl);
        end
        for (int c = 0; c <= 120; c++) begin
            if (busy === 1'b1 && a !== prev_a) begin
                prev_a = a;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s_extra_vec: got a=%h at cycle %0d want none", tag, a, c);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++; if ({a, b, ctrl} !== {e.va, e.vb, e.op}) begin
                        n_bad++; $display("FAIL %s_vec%0d: got %h %h %b want %h %h %b", tag, pops, a, b, ctrl, e.va, e.vb, e.op);
                    end
                    if (pops == 1) begin
                        n_cmp++; if (a !== 16'hE270) begin
                            n_bad++; $display("FAIL %s_second_a: got %h want e270", tag, a);
                        end
                    end
                    pops++;
                end
            end
            if (c == 119) begin
                n_cmp++; if (done !== 1'b0) begin
                    n_bad++; $display("FAIL %s_done_early: got done=%b at 119 want 0", tag, done);
                end
            end
            if (c == 120) begin
                n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || fc !== 8'd0) begin
                    n_bad++; $display("FAIL %s_done_120: got done=%b pass=%b fc=%0d want 1 1 0", tag, done, pass, fc);
                end
            end
            if (c < 120) begin @(posedge clk); #1; end
        end
        n_cmp++; if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL %s_missing_vecs: got %0d left want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_op2_fail;
        int c = 0;
        mode = 1;
        pulse_start(0);
        while (done !== 1'b1 && c < 300) begin @(posedge clk); #1; c++; end
        n_cmp++; if (c != 120) begin
            n_bad++; $display("FAIL op2_latency: got %0d want 120", c);
        end
        n_cmp++; if (fc !== 8'd8 || pass !== 1'b0) begin
            n_bad++; $display("FAIL op2_count: got fc=%0d pass=%b want 8 0", fc, pass);
        end
        n_cmp++; if (ffo !== 3'b010 || ffv !== 8'd0 || ffg !== 16'hFFFF) begin
            n_bad++; $display("FAIL op2_first: got op=%b vec=%0d got=%h want 010 0 ffff", ffo, ffv, ffg);
        end
        mode = 0;
    endtask

    task automatic test_busy_ignore;
        mode = 0;
        pulse_start(0);
        n_cmp++; if (fc !== 8'd0 || {ffo, ffv, ffg} !== 27'd0 || done !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL restart_clear: got fc=%0d op=%b vec=%0d got=%h done=%b busy=%b want cleared",
                              fc, ffo, ffv, ffg, done, busy);
        end
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            start = (c == 10 || c == 37 || c == 75 || c == 118) ? 1'b1 : 1'b0;
            if (c == 119) begin
                n_cmp++; if (done !== 1'b0) begin
                    n_bad++; $display("FAIL busy_ignore_early: got done=%b at 119 want 0", done);
                end
            end
        end
        start = 1'b0;
        n_cmp++; if (done !== 1'b1 || pass !== 1'b1) begin
            n_bad++; $display("FAIL busy_ignore_done: got done=%b pass=%b at 120 want 1 1", done, pass);
        end
    endtask

    task automatic test_reset_mid;
        pulse_start(0);
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || {a, b, ctrl} !== 35'd0 || fc !== 8'd0 || done !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: got busy=%b a=%h b=%h ctrl=%b fc=%0d done=%b want 0",
                              busy, a, b, ctrl, fc, done);
        end
        #2 rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b0 || a !== 16'h0000) begin
            n_bad++; $display("FAIL reset_mid_idle: got busy=%b a=%h want 0 0", busy, a);
        end
    endtask

    task automatic test_saturate;
        int c = 0;
        pulse_start(1);
        while (done64 !== 1'b1 && c < 1200) begin @(posedge clk); #1; c++; end
        n_cmp++; if (c != 960) begin
            n_bad++; $display("FAIL sat_latency: got %0d want 960", c);
        end
        n_cmp++; if (fc64 !== 8'd255 || pass64 !== 1'b0 || done64 !== 1'b1) begin
            n_bad++; $display("FAIL sat_count: got fc=%0d pass=%b done=%b want 255 0 1", fc64, pass64, done64);
        end
        n_cmp++; if (ffo64 !== 3'b000 || ffv64 !== 8'd0) begin
            n_bad++; $display("FAIL sat_first: got op=%b vec=%0d want 000 0", ffo64, ffv64);
        end
    endtask

    task automatic test_settle3;
        for (int c = 0; c <= 200; c++) begin
            if (c == 199) begin
                n_cmp++; if (done3 !== 1'b0) begin
                    n_bad++; $display("FAIL settle3_early: got done=%b at 199 want 0", done3);
                end
            end
            if (c < 200) begin @(posedge clk); #1; end
        end
        n_cmp++; if (done3 !== 1'b1 || pass3 !== 1'b1 || fc3 !== 8'd0) begin
            n_bad++; $display("FAIL settle3_done: got done=%b pass=%b fc=%0d want 1 1 0", done3, pass3, fc3);
        end
    endtask

    initial begin
        start = 1'b0; start64 = 1'b0; start3 = 1'b0;
        rst_n = 1'b1;
        test_reset;
        test_pass_run("run1");
        test_op2_fail;
        test_busy_ignore;
        test_pass_run("rerun");
        test_reset_mid;
        test_pass_run("post_reset");
        test_saturate;
        pulse_start(2);
        test_settle3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
